// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator blocks: floor encoding, request
// masks and the controller state codes.
package elevator_pkg;

    localparam int NUM_FLOORS = 3;

    typedef logic [1:0]            floor_t;
    typedef logic [NUM_FLOORS-1:0] floor_mask_t;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] MOVING    = 2'd1;
    localparam logic [1:0] DOOR_OPEN = 2'd2;
    localparam logic [1:0] HALT      = 2'd3;

    function automatic floor_mask_t floor_onehot(floor_t f);
        return floor_mask_t'(1) << f;
    endfunction

    function automatic floor_mask_t floors_above(floor_t f);
        floor_mask_t m;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            m[i] = (i > int'(f));
        end
        return m;
    endfunction

    function automatic floor_mask_t floors_below(floor_t f);
        floor_mask_t m;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            m[i] = (i < int'(f));
        end
        return m;
    endfunction

endpackage

// File: rtl/elevator_controller_if.sv
// Button/sensor inputs and car status outputs of the elevator controller.
interface elevator_controller_if;
    import elevator_pkg::*;

    logic        button1;
    logic        button2;
    logic        button3;
    logic        move_clk;
    logic        sos_mode;
    logic        weight_limit_exceeded;
    logic        moving;
    logic        direction_up;
    floor_t      current_floor;
    logic        door_open;
    floor_mask_t pending;
    logic        arrived;

    modport master (
        output button1, button2, button3, move_clk, sos_mode, weight_limit_exceeded,
        input  moving, direction_up, current_floor, door_open, pending, arrived
    );

    modport slave (
        input  button1, button2, button3, move_clk, sos_mode, weight_limit_exceeded,
        output moving, direction_up, current_floor, door_open, pending, arrived
    );

endinterface

// File: rtl/elevator_controller_door_timer.sv
// Loadable down-counter for the door-open interval; done while the count is zero.
module door_timer #(
    parameter int CYCLES = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic hold,
    output logic done
);

    localparam int W = $clog2(CYCLES);

    logic [W-1:0] count;

    // Load wins over counting; the count parks at zero until the next load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= W'(CYCLES - 1);
        end else if (!hold && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/elevator_controller.sv
// Three-floor elevator scheduler: latches requests, picks direction with a
// collective (SCAN) policy, steps floors on move ticks and runs the door interval.
module elevator_controller
    import elevator_pkg::*;
#(
    parameter int DOOR_CYCLES = 20,
    parameter int RESET_FLOOR = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    elevator_controller_if.slave bus
);

    logic [1:0]  state, state_next;
    floor_t      floor_q, floor_next;
    logic        dir_up_q, dir_up_next;
    floor_mask_t pending_q, pending_next;
    logic        door_q, door_next;
    logic        arrived_q, arrived_next;
    logic        move_clk_q;

    floor_mask_t buttons, here, ahead, behind, step_mask, set_mask, clear_mask;
    floor_t      step_floor;
    logic        tick, here_pressed, hold_door, timer_load, timer_done;

    assign buttons      = {bus.button3, bus.button2, bus.button1};
    assign here         = floor_onehot(floor_q);
    assign here_pressed = |(buttons & here);
    assign hold_door    = bus.weight_limit_exceeded | here_pressed;
    assign ahead        = dir_up_q ? floors_above(floor_q) : floors_below(floor_q);
    assign behind       = dir_up_q ? floors_below(floor_q) : floors_above(floor_q);
    assign step_floor   = dir_up_q ? floor_q + 2'd1 : floor_q - 2'd1;
    assign step_mask    = floor_onehot(step_floor);
    assign tick         = bus.move_clk & ~move_clk_q;

    // A press for the floor the car is parked at opens the door instead of queueing.
    assign set_mask = (state == IDLE || state == DOOR_OPEN) ? (buttons & ~here) : buttons;

    always_comb begin
        state_next   = state;
        floor_next   = floor_q;
        dir_up_next  = dir_up_q;
        door_next    = door_q;
        arrived_next = 1'b0;
        clear_mask   = '0;
        timer_load   = 1'b0;

        if (bus.sos_mode) begin
            state_next = HALT;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.weight_limit_exceeded) begin
                        if (|(pending_q & here)) begin
                            clear_mask   = here;
                            arrived_next = 1'b1;
                            door_next    = 1'b1;
                            timer_load   = 1'b1;
                            state_next   = DOOR_OPEN;
                        end else if (here_pressed) begin
                            door_next  = 1'b1;
                            timer_load = 1'b1;
                            state_next = DOOR_OPEN;
                        end else if (|(pending_q & ahead)) begin
                            state_next = MOVING;
                        end else if (|(pending_q & behind)) begin
                            dir_up_next = ~dir_up_q;
                            state_next  = MOVING;
                        end
                    end
                end
                MOVING: begin
                    // Requests are never dropped in flight, so a target stays ahead;
                    // falling back to IDLE keeps the car inside the shaft regardless.
                    if (!(|(pending_q & ahead))) begin
                        state_next = IDLE;
                    end else if (tick) begin
                        floor_next = step_floor;
                        if (|(pending_q & step_mask)) begin
                            clear_mask   = step_mask;
                            arrived_next = 1'b1;
                            door_next    = 1'b1;
                            timer_load   = 1'b1;
                            state_next   = DOOR_OPEN;
                        end
                    end
                end
                DOOR_OPEN: begin
                    if (hold_door) begin
                        timer_load = 1'b1;
                    end else if (timer_done) begin
                        door_next  = 1'b0;
                        state_next = IDLE;
                    end
                end
                default: begin
                    if (door_q) begin
                        timer_load = 1'b1;
                        state_next = DOOR_OPEN;
                    end else begin
                        state_next = IDLE;
                    end
                end
            endcase
        end

        pending_next = (pending_q | set_mask) & ~clear_mask;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            floor_q    <= floor_t'(RESET_FLOOR);
            dir_up_q   <= 1'b1;
            pending_q  <= '0;
            door_q     <= 1'b0;
            arrived_q  <= 1'b0;
            move_clk_q <= 1'b0;
        end else begin
            state      <= state_next;
            floor_q    <= floor_next;
            dir_up_q   <= dir_up_next;
            pending_q  <= pending_next;
            door_q     <= door_next;
            arrived_q  <= arrived_next;
            move_clk_q <= bus.move_clk;
        end
    end

    door_timer #(
        .CYCLES (DOOR_CYCLES)
    ) u_door_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .hold  (state != DOOR_OPEN),
        .done  (timer_done)
    );

    assign bus.moving        = (state == MOVING);
    assign bus.direction_up  = dir_up_q;
    assign bus.current_floor = floor_q;
    assign bus.door_open     = door_q;
    assign bus.pending       = pending_q;
    assign bus.arrived       = arrived_q;

endmodule

// File: tb/tb_elevator_controller.sv
// Directed scenarios plus randomized traffic for elevator_controller, checked
// every cycle against a floor/request reference model.
module tb_elevator_controller;
    import elevator_pkg::*;

    localparam int DC = 8;

    typedef enum {M_REST, M_TRAVEL, M_DOOR, M_STOP} mmode_e;

    logic clk = 1'b0;
    logic reset;
    int   numVectors;
    int   numMiscompares;

    // Reference model state
    mmode_e mMode;
    int     mFloor;
    bit     mUp;
    bit     mReq[3];
    bit     mDoor;
    bit     mArrived;
    int     mTimer;
    bit     mPrevMc;
    bit     iBtn[3];
    bit     iMc, iSos, iWt;

    elevator_controller_if bus();

    elevator_controller #(
        .DOOR_CYCLES (DC),
        .RESET_FLOOR (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        numVectors++;
        if (observed !== expected) begin
            numMiscompares++;
            $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] b, input logic mc, input logic s, input logic w);
        bus.button1 = b[0];
        bus.button2 = b[1];
        bus.button3 = b[2];
        bus.move_clk = mc;
        bus.sos_mode = s;
        bus.weight_limit_exceeded = w;
        iBtn[0] = b[0];
        iBtn[1] = b[1];
        iBtn[2] = b[2];
        iMc = mc;
        iSos = s;
        iWt = w;
    endtask

    task automatic modelReset();
        mMode = M_REST;
        mFloor = 0;
        mUp = 1'b1;
        for (int f = 0; f < 3; f++) mReq[f] = 1'b0;
        mDoor = 1'b0;
        mArrived = 1'b0;
        mTimer = 0;
        mPrevMc = 1'b0;
    endtask

    task automatic openDoor();
        mDoor = 1'b1;
        mTimer = DC - 1;
        mMode = M_DOOR;
    endtask

    // One clock of the scheduling rules, applied to the inputs of this cycle.
    task automatic modelStep();
        bit nextReq[3];
        bit tickSeen, pressedHere, wantUp, wantDown;
        tickSeen = iMc && !mPrevMc;
        mPrevMc = iMc;
        pressedHere = iBtn[mFloor];
        mArrived = 1'b0;
        wantUp = 1'b0;
        wantDown = 1'b0;
        for (int f = 0; f < 3; f++) begin
            nextReq[f] = mReq[f] | (iBtn[f] && !(f == mFloor && (mMode == M_REST || mMode == M_DOOR)));
            if (mReq[f] && f > mFloor) wantUp = 1'b1;
            if (mReq[f] && f < mFloor) wantDown = 1'b1;
        end
        if (iSos) begin
            mMode = M_STOP;
        end else begin
            case (mMode)
                M_REST: begin
                    if (!iWt) begin
                        if (mReq[mFloor]) begin
                            nextReq[mFloor] = 1'b0;
                            mArrived = 1'b1;
                            openDoor();
                        end else if (pressedHere) begin
                            openDoor();
                        end else if (mUp ? wantUp : wantDown) begin
                            mMode = M_TRAVEL;
                        end else if (mUp ? wantDown : wantUp) begin
                            mUp = !mUp;
                            mMode = M_TRAVEL;
                        end
                    end
                end
                M_TRAVEL: begin
                    if (tickSeen) begin
                        mFloor = mUp ? mFloor + 1 : mFloor - 1;
                        if (mReq[mFloor]) begin
                            nextReq[mFloor] = 1'b0;
                            mArrived = 1'b1;
                            openDoor();
                        end
                    end
                end
                M_DOOR: begin
                    if (iWt || pressedHere) begin
                        mTimer = DC - 1;
                    end else if (mTimer == 0) begin
                        mDoor = 1'b0;
                        mMode = M_REST;
                    end else begin
                        mTimer--;
                    end
                end
                default: begin
                    if (mDoor) openDoor();
                    else mMode = M_REST;
                end
            endcase
        end
        for (int f = 0; f < 3; f++) mReq[f] = nextReq[f];
    endtask

    task automatic compareAll();
        checkOutput("moving", 32'(bus.moving), 32'(mMode == M_TRAVEL));
        checkOutput("direction_up", 32'(bus.direction_up), 32'(mUp));
        checkOutput("current_floor", 32'(bus.current_floor), 32'(mFloor));
        checkOutput("door_open", 32'(bus.door_open), 32'(mDoor));
        checkOutput("pending", 32'(bus.pending), 32'({mReq[2], mReq[1], mReq[0]}));
        checkOutput("arrived", 32'(bus.arrived), 32'(mArrived));
    endtask

    // Called at a falling edge; drives one cycle, checks just after the rising edge.
    task automatic runCycle(input logic [2:0] b, input logic mc, input logic s, input logic w);
        applyStimulus(b, mc, s, w);
        modelStep();
        @(posedge clk);
        #1;
        compareAll();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) runCycle(3'b000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tickPulse();
        runCycle(3'b000, 1'b1, 1'b0, 1'b0);
        runCycle(3'b000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_moving"}, 32'(bus.moving), 32'd0);
        checkOutput({tag, "_dir"}, 32'(bus.direction_up), 32'd1);
        checkOutput({tag, "_floor"}, 32'(bus.current_floor), 32'd0);
        checkOutput({tag, "_door"}, 32'(bus.door_open), 32'd0);
        checkOutput({tag, "_pending"}, 32'(bus.pending), 32'd0);
        checkOutput({tag, "_arrived"}, 32'(bus.arrived), 32'd0);
    endtask

    initial begin
        logic [2:0] b;
        logic       mcLevel;
        int         mcLeft, sosLeft, wtLeft;

        numVectors = 0;
        numMiscompares = 0;
        reset = 1'b1;
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
        modelReset();
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        reset = 1'b0;

        $display("[TB] floor 0 -> 2 trip");
        runCycle(3'b100, 1'b0, 1'b0, 1'b0);
        checkOutput("s1_pending", 32'(bus.pending), 32'd4);
        runCycle(3'b000, 1'b0, 1'b0, 1'b0);
        checkOutput("s1_moving", 32'(bus.moving), 32'd1);
        checkOutput("s1_dir", 32'(bus.direction_up), 32'd1);
        idle(1);
        tickPulse();
        checkOutput("s1_mid_floor", 32'(bus.current_floor), 32'd1);
        runCycle(3'b000, 1'b1, 1'b0, 1'b0);
        checkOutput("s1_arrived", 32'(bus.arrived), 32'd1);
        checkOutput("s1_floor", 32'(bus.current_floor), 32'd2);
        checkOutput("s1_stopped", 32'(bus.moving), 32'd0);
        idle(DC - 1);
        checkOutput("s1_door_held", 32'(bus.door_open), 32'd1);
        idle(1);
        checkOutput("s1_door_closed", 32'(bus.door_open), 32'd0);

        $display("[TB] collective service with reversal");
        runCycle(3'b010, 1'b0, 1'b0, 1'b0);
        idle(2);
        tickPulse();
        idle(DC + 2);
        checkOutput("s2_floor1", 32'(bus.current_floor), 32'd1);
        runCycle(3'b100, 1'b0, 1'b0, 1'b0);
        idle(1);
        runCycle(3'b001, 1'b0, 1'b0, 1'b0);
        checkOutput("s2_pending_both", 32'(bus.pending), 32'd5);
        tickPulse();
        checkOutput("s2_top_first", 32'(bus.current_floor), 32'd2);
        idle(DC + 3);
        checkOutput("s2_reversed", 32'(bus.direction_up), 32'd0);
        tickPulse();
        tickPulse();
        idle(DC + 2);
        checkOutput("s2_floor0", 32'(bus.current_floor), 32'd0);
        checkOutput("s2_pending_empty", 32'(bus.pending), 32'd0);

        $display("[TB] current-floor press and reload");
        runCycle(3'b001, 1'b0, 1'b0, 1'b0);
        checkOutput("s5_door", 32'(bus.door_open), 32'd1);
        checkOutput("s5_pending", 32'(bus.pending), 32'd0);
        idle(DC - 3);
        runCycle(3'b001, 1'b0, 1'b0, 1'b0);
        idle(DC - 1);
        checkOutput("s5_reloaded", 32'(bus.door_open), 32'd1);
        idle(1);
        checkOutput("s5_closed", 32'(bus.door_open), 32'd0);

        $display("[TB] overweight hold");
        runCycle(3'b001, 1'b0, 1'b0, 1'b0);
        repeat (50) runCycle(3'b000, 1'b0, 1'b0, 1'b1);
        checkOutput("s3_held", 32'(bus.door_open), 32'd1);
        idle(DC - 1);
        checkOutput("s3_after_release", 32'(bus.door_open), 32'd1);
        idle(1);
        checkOutput("s3_closed", 32'(bus.door_open), 32'd0);

        $display("[TB] sos between ticks");
        runCycle(3'b100, 1'b0, 1'b0, 1'b0);
        idle(2);
        tickPulse();
        runCycle(3'b000, 1'b0, 1'b1, 1'b0);
        checkOutput("s4_halted", 32'(bus.moving), 32'd0);
        repeat (3) begin
            runCycle(3'b000, 1'b1, 1'b1, 1'b0);
            runCycle(3'b000, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("s4_floor_frozen", 32'(bus.current_floor), 32'd1);
        idle(2);
        checkOutput("s4_resumed", 32'(bus.moving), 32'd1);
        tickPulse();
        idle(DC + 2);
        checkOutput("s4_target", 32'(bus.current_floor), 32'd2);

        $display("[TB] reset mid-move");
        runCycle(3'b001, 1'b0, 1'b0, 1'b0);
        idle(2);
        tickPulse();
        reset = 1'b1;
        #1;
        checkResetValues("async_reset");
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
        modelReset();
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] random traffic");
        mcLevel = 1'b0;
        mcLeft = 3;
        sosLeft = 0;
        wtLeft = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int f = 0; f < 3; f++) b[f] = ($urandom_range(0, 17) == 0);
            if (mcLeft == 0) begin
                mcLevel = !mcLevel;
                mcLeft = $urandom_range(1, 5);
            end else begin
                mcLeft--;
            end
            if (sosLeft > 0) sosLeft--;
            else if ($urandom_range(0, 199) == 0) sosLeft = $urandom_range(2, 12);
            if (wtLeft > 0) wtLeft--;
            else if ($urandom_range(0, 99) == 0) wtLeft = $urandom_range(1, 30);
            runCycle(b, mcLevel, sosLeft > 0, wtLeft > 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
        $finish;
    end

endmodule

// File: doc/elevator_controller.md
# elevator_controller

Floor-request scheduler and motion sequencer for the three-floor elevator. It latches hall/car button presses, chooses the travel direction with a collective (SCAN) policy and asserts `moving` to the movement-tick generator. It advances the floor position on each move tick and runs the door-open interval at each served floor. SOS and overweight conditions halt or hold the car.

## Interface
Parameters:
- `DOOR_CYCLES`, 20: `clk` cycles the door stays open after the last reason to hold it.
- `RESET_FLOOR`, 0: floor index (0..2) loaded at reset.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `button1` / `button2` / `button3`  in  1 each  level requests for floors 0 / 1 / 2; sampled every cycle.
- `move_clk`  in  1  tick from the movement-frequency generator; each 0→1 edge means one floor travelled.
- `sos_mode`  in  1  emergency halt, level.
- `weight_limit_exceeded`  in  1  overweight, level.
- `moving`  out  1  car in motion; feeds the generator's `moving` input.
- `direction_up`  out  1  1 = ascending, 0 = descending; meaningful while `moving`.
- `current_floor`  out  2  floor index 0..2; value 3 is never driven.
- `door_open`  out  1  door open.
- `pending`  out  3  latched requests; bit i = floor i.
- `arrived`  out  1  one-cycle pulse when a floor is served.

## Operation
- Reset values: `moving`=0, `direction_up`=1, `current_floor`=RESET_FLOOR, `door_open`=0, `pending`=000, `arrived`=0, state IDLE, door timer 0, `move_clk` edge register 0.
- Request latch: a high button sets its `pending` bit, which is sticky until the floor is served. A press for `current_floor` while in IDLE or DOOR_OPEN does not set the bit. It opens the door, or reloads the door timer if the door is already open.
- States:
  - IDLE. If `pending` has a bit at `current_floor`, go to DOOR_OPEN. Otherwise, if any request lies ahead in `direction_up`, go to MOVING. Otherwise, if any request lies behind, flip `direction_up` and go to MOVING. Otherwise stay in IDLE.
  - MOVING. `moving`=1. On each `move_clk` rising edge, step `current_floor` by ±1. If the new floor is pending, clear its bit, pulse `arrived`, and go to DOOR_OPEN. Otherwise continue. Floor 2 with up, or floor 0 with down, can never be reached with `moving`=1; the direction is chosen before departure.
  - DOOR_OPEN. `door_open`=1 and the timer loads DOOR_CYCLES−1. The timer decrements each cycle and reloads while `weight_limit_exceeded`=1 or the current-floor button is high. At timer 0 with no overweight, close the door and go to IDLE.
  - HALT. Entered from any state when `sos_mode`=1; this has priority over everything. `moving`=0, `door_open` holds its value, and `move_clk` edges are ignored. Buttons still latch. On `sos_mode`=0, go to DOOR_OPEN with the timer reloaded if the door is open, otherwise go to IDLE. IDLE re-runs the direction decision.
- Weight limit: in IDLE it blocks leaving IDLE. The door is held open while the door is open.
- Timer width is $clog2(DOOR_CYCLES). DOOR_CYCLES ≥ 2.

## Timing
- Button high at cycle n sets `pending` at n+1. An IDLE→MOVING decision asserts `moving` at n+2.
- `move_clk` edge detection uses a registered copy, so an edge seen at cycle n updates `current_floor`, `arrived` and `door_open` at n+1. `moving` falls in the same cycle.
- A door opened at cycle n closes at n+DOOR_CYCLES if nothing holds it.
- If a new request for the arriving floor comes in the same cycle as the arrival, it is served: the bit ends cleared.
- Reset asserted mid-move returns all outputs to their reset values immediately; latched requests are lost.

## Structure
- Package `elevator_pkg` holds the state enum (IDLE, MOVING, DOOR_OPEN, HALT), the `floor_t` 2-bit typedef and `NUM_FLOORS`=3. The generator and display blocks share this package.
- Sub-module `door_timer` is a loadable down-counter with load and hold inputs and a done output. The direction decision stays inline as combinational ahead/behind masks.

## Test plan
- Reset at floor 0; press `button3` for 1 cycle → `pending`=100, `moving`=1, `direction_up`=1. Two `move_clk` edges → `current_floor`=2, `arrived` pulse, `door_open` for DOOR_CYCLES, then IDLE.
- At floor 1 moving up toward 2, `button1` pressed → floor 2 is served first, then direction flips and floor 0 is served. `pending` ends 000.
- Door open at floor 0 with `weight_limit_exceeded` held for 50 cycles → door stays open; it closes DOOR_CYCLES cycles after release.
- `sos_mode` raised between ticks while moving → `moving`=0 next cycle and `move_clk` edges are ignored. On release, travel resumes to the same target.
- Press the current-floor button while idle → door opens with `pending` unchanged. Pressing it again during the open interval reloads the timer.
- Assert `reset` mid-move → all outputs return to reset values asynchronously.
